// File: rtl/oam_dma.sv
// Sprite DMA engine: copies one 256-byte CPU page into PPU OAMDATA with
// 2A03-compatible halt/align/read/write cycle timing (513 or 514 CPU cycles).
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [2:0]  OAMDATA_ADDR = 3'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic        dma_active,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data_i,
   output logic        ppu_cs,
   output logic        ppu_rw,
   output logic [2:0]  ppu_addr,
   output logic [7:0]  ppu_data,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t     state;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] buf_q;
   logic       par;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         page    <= 8'h00;
         idx     <= 8'h00;
         buf_q   <= 8'h00;
         par     <= 1'b0;
         cpu_rdy <= 1'b1;
      end else begin
         if (cpu_ce)
            par <= ~par;
         case (state)
            // The trigger is taken on any clk, not only on cpu_ce edges.
            IDLE: begin
               if (cpu_we && (cpu_addr_i == DMA_REG_ADDR)) begin
                  page    <= cpu_data_i;
                  idx     <= 8'h00;
                  state   <= HALT;
                  cpu_rdy <= 1'b0;
               end
            end
            HALT: begin
               if (cpu_ce)
                  state <= par ? READ : ALIGN;
            end
            ALIGN: begin
               if (cpu_ce)
                  state <= READ;
            end
            READ: begin
               if (cpu_ce) begin
                  buf_q <= mem_data_i;
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (cpu_ce) begin
                  if (idx == 8'hFF) begin
                     state   <= IDLE;
                     cpu_rdy <= 1'b1;
                     idx     <= 8'h00;
                  end else begin
                     idx   <= idx + 8'd1;
                     state <= READ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus outputs decode straight from the registered state so reset clears them at once.
   assign mem_rd     = (state == READ);
   assign ppu_cs     = (state == WRITE);
   assign ppu_rw     = ~(state == WRITE);
   assign ppu_data   = buf_q;
   assign ppu_addr   = OAMDATA_ADDR;
   assign mem_addr   = {page, idx};
   assign dma_active = (state != IDLE);
   assign state_dbg  = state;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table of CPU writes plus hand-written
// retrigger and mid-transfer reset sequences, with a data/address scoreboard.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_ce = 1'b0;
   logic [15:0] cpu_addr_i = 16'h0000;
   logic [7:0]  cpu_data_i = 8'h00;
   logic        cpu_we = 1'b0;
   logic        cpu_rdy, dma_active, mem_rd, ppu_cs, ppu_rw;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_i, ppu_data;
   logic [2:0]  ppu_addr, state_dbg;

   oam_dma dut (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
      .dma_active(dma_active), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data_i(mem_data_i), .ppu_cs(ppu_cs), .ppu_rw(ppu_rw),
      .ppu_addr(ppu_addr), .ppu_data(ppu_data), .state_dbg(state_dbg)
   );

   // CPU memory model: byte at low address i is i ^ A5.
   assign mem_data_i = mem_addr[7:0] ^ 8'hA5;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_data_q[$];
   logic [15:0] exp_addr_q[$];

   int  writes_cnt, active_ce, low_ce;
   bit  had_write, overlap_bad, gap_bad, rd_seen, first_rd_even;
   bit  prev_cs = 1'b0;
   bit  par_m = 1'b0;
   int  ce_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // cpu_ce: one clk in three, changed 1 ns after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ce_cnt = (ce_cnt == 2) ? 0 : ce_cnt + 1;
         cpu_ce = (ce_cnt == 2);
      end
   end

   // Reference CPU-cycle parity.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst) par_m = 1'b0;
         else if (cpu_ce) par_m = ~par_m;
      end
   end

   // Monitor / scoreboard, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_cs = 1'b0;
         end else begin
            if (ppu_cs && !prev_cs) begin
               writes_cnt++;
               if (had_write && low_ce < 1) gap_bad = 1'b1;
               low_ce    = 0;
               had_write = 1'b1;
               chk("ppu_rw", ppu_rw, 0);
               chk("ppu_addr", ppu_addr, 4);
               if (exp_data_q.size() == 0) chk("extra_write", 1, 0);
               else chk("ppu_data", ppu_data, exp_data_q.pop_front());
            end
            if (ppu_cs && mem_rd) overlap_bad = 1'b1;
            if (!ppu_cs && cpu_ce && had_write) low_ce++;
            if (mem_rd && !rd_seen) begin
               rd_seen       = 1'b1;
               first_rd_even = (par_m == 1'b0);
            end
            if (mem_rd && cpu_ce) begin
               if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
               else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (cpu_ce && dma_active) active_ce++;
            prev_cs = ppu_cs;
         end
      end
   end

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr_i = a;
      cpu_data_i = d;
      cpu_we     = 1'b1;
      @(posedge clk);
      #2;
      cpu_we     = 1'b0;
   endtask

   // mode 1: trigger on an edge without cpu_ce, with parity want_par at HALT end.
   // mode 2: trigger on the same edge as a cpu_ce.
   task automatic start_dma(input logic [7:0] pg, input int mode, input bit want_par,
                            output int exp_cnt);
      bit end_par;
      bit found;
      writes_cnt = 0; active_ce = 0; low_ce = 0; had_write = 0;
      overlap_bad = 0; gap_bad = 0; rd_seen = 0; first_rd_even = 0;
      exp_data_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < 256; i++) begin
         exp_data_q.push_back(8'(i) ^ 8'hA5);
         exp_addr_q.push_back({pg, 8'(i)});
      end
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk);
         #2;
         if (mode == 1 && !cpu_ce && par_m == want_par) found = 1'b1;
         if (mode == 2 && cpu_ce) found = 1'b1;
      end
      chk("align_timeout", found, 1);
      end_par = (mode == 2) ? ~par_m : par_m;
      exp_cnt = end_par ? 513 : 514;
      cpu_write(16'h4014, pg);
      chk("trig_state", state_dbg, 1);
      chk("trig_rdy", cpu_rdy, 0);
      chk("trig_active", dma_active, 1);
   endtask

   task automatic wait_idle(input int max_clk);
      for (int k = 0; k < max_clk && dma_active; k++) @(posedge clk);
      #2;
      chk("idle_timeout", dma_active, 0);
   endtask

   task automatic end_checks(input int exp_cnt);
      wait_idle(3000);
      chk("rdy_after", cpu_rdy, 1);
      chk("write_count", writes_cnt, 256);
      chk("active_ce", active_ce, exp_cnt);
      chk("data_q_left", exp_data_q.size(), 0);
      chk("addr_q_left", exp_addr_q.size(), 0);
      chk("cs_rd_overlap", overlap_bad, 0);
      chk("cs_gap", gap_bad, 0);
      chk("first_rd_even", first_rd_even, 1);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      bit          trig;
      int          mode;
      bit          want_par;
   } vec_t;

   vec_t vecs[6];
   int   exp_cnt;
   bit   found;

   initial begin
      vecs[0] = '{16'h4013, 8'h33, 1'b0, 0, 1'b0};
      vecs[1] = '{16'h4015, 8'h44, 1'b0, 0, 1'b0};
      vecs[2] = '{16'h0014, 8'h55, 1'b0, 0, 1'b0};
      vecs[3] = '{16'h4014, 8'h02, 1'b1, 1, 1'b1};
      vecs[4] = '{16'h4014, 8'h03, 1'b1, 1, 1'b0};
      vecs[5] = '{16'h4014, 8'h81, 1'b1, 2, 1'b0};

      repeat (4) @(posedge clk);
      #2;
      chk("rst_state", state_dbg, 0);
      chk("rst_rdy", cpu_rdy, 1);
      chk("rst_active", dma_active, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_cs", ppu_cs, 0);
      chk("rst_rw", ppu_rw, 1);
      chk("rst_ppu_addr", ppu_addr, 4);
      chk("rst_ppu_data", ppu_data, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].trig) begin
            start_dma(vecs[v].data, vecs[v].mode, vecs[v].want_par, exp_cnt);
            end_checks(exp_cnt);
         end else begin
            cpu_write(vecs[v].addr, vecs[v].data);
            chk("nt_state", state_dbg, 0);
            chk("nt_rdy", cpu_rdy, 1);
            repeat (6) @(posedge clk);
            #2;
            chk("nt_active", dma_active, 0);
            chk("nt_mem_rd", mem_rd, 0);
         end
      end

      // Retrigger during an active transfer must be ignored.
      start_dma(8'h02, 1, 1'b1, exp_cnt);
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(posedge clk);
         #2;
         if (writes_cnt == 41) found = 1'b1;
      end
      chk("retrig_wait", found, 1);
      cpu_write(16'h4014, 8'h07);
      chk("retrig_page", mem_addr[15:8], 8'h02);
      end_checks(exp_cnt);

      // Asynchronous reset while byte 100 is being written.
      start_dma(8'h05, 1, 1'b0, exp_cnt);
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(posedge clk);
         #2;
         if (writes_cnt == 101 && ppu_cs) found = 1'b1;
      end
      chk("mid_wait", found, 1);
      rst = 1'b0;
      #1;
      chk("mid_cs", ppu_cs, 0);
      chk("mid_rdy", cpu_rdy, 1);
      chk("mid_active", dma_active, 0);
      chk("mid_mem_addr", mem_addr, 0);
      chk("mid_ppu_data", ppu_data, 0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("post_rst_idle", dma_active, 0);
      start_dma(8'h09, 1, 1'b1, exp_cnt);
      end_checks(exp_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA engine sitting directly upstream of the PPU's CPU register port. A CPU write to the DMA page register halts the CPU, reads 256 bytes from CPU page `{page,8'h00}`–`{page,8'hFF}`, and writes each byte into the PPU's OAMDATA register through the same `cs`/`rw`/`addr`/`data` register interface the CPU uses. The bus, parity and cycle behaviour matches the 2A03 $4014 DMA, so the transfer takes 513 or 514 CPU cycles.

## Interface

Parameters:
- `DMA_REG_ADDR`, default 16'h4014: CPU address that triggers a DMA.
- `OAMDATA_ADDR`, default 3'd4: PPU register index driven on `ppu_addr`.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_ce` in 1: one-`clk` pulse marking the end of each CPU cycle. All state transitions happen on `clk` edges where `cpu_ce`=1.
- `cpu_addr_i` in 16: CPU address bus.
- `cpu_data_i` in 8: CPU write data.
- `cpu_we` in 1: CPU write strobe.
- `cpu_rdy` out 1: 0 halts the CPU.
- `dma_active` out 1: 1 whenever the state is not IDLE.
- `mem_addr` out 16: DMA read address, `{page, idx}`.
- `mem_rd` out 1: DMA owns the bus and is reading this CPU cycle.
- `mem_data_i` in 8: read data, valid at the `cpu_ce` that ends a READ cycle.
- `ppu_cs` out 1: PPU register chip select. The PPU acts on its rising edge.
- `ppu_rw` out 1: 0 means write.
- `ppu_addr` out 3: always `OAMDATA_ADDR`.
- `ppu_data` out 8: byte being written.

## Operation

- Registers:
  - `state` ∈ {IDLE, HALT, ALIGN, READ, WRITE}
  - `page[7:0]`
  - `idx[7:0]`
  - `buf[7:0]`
  - `par`: parity of the current CPU cycle, 0 = even/get.
- `par` toggles on every `cpu_ce`, independent of `state`.
- **Trigger:** on any `clk` with `state`=IDLE, `cpu_we`=1 and `cpu_addr_i`=`DMA_REG_ADDR`:
  - `page` <= `cpu_data_i`, `idx` <= 0, `state` <= HALT, `cpu_rdy` <= 0.
  - No `cpu_ce` is needed for the trigger itself.
- Transitions, on `cpu_ce` only:
  - HALT -> READ if `par`=1 (next cycle is even), else HALT -> ALIGN.
  - ALIGN -> READ.
  - READ -> WRITE, with `buf` <= `mem_data_i`.
  - WRITE -> READ with `idx` <= `idx`+1, when `idx`≠255.
  - WRITE -> IDLE with `cpu_rdy` <= 1 and `idx` <= 0, when `idx`=255.
- Output decode from the registered `state`:
  - `mem_rd` = (READ)
  - `ppu_cs` = (WRITE)
  - `ppu_rw` = ~(WRITE)
  - `ppu_data` = `buf`
  - `mem_addr` = `{page, idx}`
  - `dma_active` = (≠IDLE)
- Because a READ cycle separates every pair of WRITE cycles, `ppu_cs` is low for at least one full CPU cycle between writes. This guarantees one PPU rising-edge event per byte.
- **Width/wrap:** `idx` is 8-bit. `mem_addr` never crosses the page: after xxFF the transfer ends and does not wrap to the next page.
- Boundary behaviour:
  - A trigger write while `state`≠IDLE is ignored; `page` is unchanged.
  - A trigger and `cpu_ce` in the same `clk`: the trigger is taken, and `state` is HALT after that edge.
  - `rst` low at any time asynchronously forces the reset values, even mid-transfer. The PPU sees `ppu_cs` fall and no further writes occur.

## Timing

- Reset values:
  - `state`=IDLE, `par`=0, `page`=0, `idx`=0, `buf`=0.
  - `cpu_rdy`=1, `dma_active`=0, `mem_rd`=0, `mem_addr`=0.
  - `ppu_cs`=0, `ppu_rw`=1, `ppu_addr`=`OAMDATA_ADDR`, `ppu_data`=0.
- `cpu_rdy` falls one `clk` after the trigger edge.
- Number of `cpu_ce` pulses with `dma_active`=1:
  - 1 (HALT) + 512 = 513 when `par`=1 at the end of HALT.
  - 514 otherwise, including ALIGN.
- `cpu_rdy` and `dma_active` return high/low one `clk` after the final WRITE's `cpu_ce`.
- Byte n timing:
  - `mem_addr`={page,n} is held for the whole READ cycle.
  - `ppu_data` = byte n is stable from the start of the WRITE cycle. `ppu_cs` rises in that same cycle and stays high until the WRITE's `cpu_ce`.
- Sustained rate: one byte per 2 CPU cycles. No backpressure input exists.

## Test plan

- **Basic transfer.** Reset, then `cpu_ce` every 3 `clk`. Write 8'h02 to $4014 with memory[i]=i^8'hA5.
  - Expect 256 `ppu_cs` rising edges with `ppu_rw`=0, `ppu_addr`=4, and data i^A5 in order.
  - Expect `mem_addr` from 16'h0200 to 16'h02FF.
- **Parity.** Trigger with `par`=1 at the end of HALT, then with `par`=0.
  - Expect 513 and 514 `cpu_ce` pulses with `cpu_rdy`=0, respectively.
  - Expect `mem_rd` to first assert only in an even cycle.
- **Retrigger.** Write 8'h07 to $4014 at byte 40 of an active DMA.
  - Expect it ignored: `mem_addr`[15:8] stays at the original page and the transfer still completes with exactly 256 writes.
- **CS gap.** Monitor `ppu_cs` throughout a transfer.
  - Expect low for ≥1 full CPU cycle between consecutive highs, and never high while `mem_rd`=1.
- **Reset mid-transfer.** Assert `rst`=0 during the WRITE of byte 100.
  - Expect immediately (same `clk`, async): `ppu_cs`=0, `cpu_rdy`=1, `dma_active`=0, `mem_addr`=0.
  - After release, a new trigger transfers a full 256 bytes.
- **Non-trigger writes.** Write to $4013 and $4015.
  - Expect no state change and `cpu_rdy` stays 1.
